// File: rtl/u_ifu_pc_gen_pkg.sv
// rtl/u_ifu_pc_gen_pkg.sv - core defines and state type for the fetch PC generator
package u_ifu_pc_gen_pkg;

    localparam int PC_WIDTH         = 32;
    localparam int EXCEPTION_NUM    = 2;
    localparam int EXC_MISALIGN_BIT = 1;
    localparam int PC_STEP          = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        KILL = 2'd2,
        HALT = 2'd3
    } pc_state_e;

    // A fetch address is misaligned when either of its two low bits is set
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/u_ifu_pc_gen_if.sv
// rtl/u_ifu_pc_gen_if.sv - start/BRU/stall inputs and fetch outputs of the PC generator
interface u_ifu_pc_gen_if #(
    parameter int PC_WIDTH      = u_ifu_pc_gen_pkg::PC_WIDTH,
    parameter int EXCEPTION_NUM = u_ifu_pc_gen_pkg::EXCEPTION_NUM
);
    logic                     start_pulse;
    logic [PC_WIDTH-1:0]      start_pc;
    logic [EXCEPTION_NUM-1:0] core_configuration;
    logic                     bru_flush;
    logic [PC_WIDTH-1:0]      bru_redir_pc;
    logic                     id_stall;
    logic [PC_WIDTH-1:0]      pc_out;
    logic                     pc_vld;
    logic                     ifu_kill;
    logic                     exc_misalign;
    logic                     core_busy;

    // Core control side: issues start, redirects and stalls, observes fetch outputs
    modport master (
        output start_pulse, start_pc, core_configuration,
        output bru_flush, bru_redir_pc, id_stall,
        input  pc_out, pc_vld, ifu_kill, exc_misalign, core_busy
    );

    // PC generator side
    modport slave (
        input  start_pulse, start_pc, core_configuration,
        input  bru_flush, bru_redir_pc, id_stall,
        output pc_out, pc_vld, ifu_kill, exc_misalign, core_busy
    );
endinterface

// File: rtl/u_ifu_pc_gen.sv
// rtl/u_ifu_pc_gen.sv - fetch-stage PC generator with BRU redirect, kill bubble and misalign trap
module u_ifu_pc_gen #(
    parameter int PC_WIDTH      = u_ifu_pc_gen_pkg::PC_WIDTH,
    parameter int EXCEPTION_NUM = u_ifu_pc_gen_pkg::EXCEPTION_NUM,
    parameter int PC_STEP       = u_ifu_pc_gen_pkg::PC_STEP
) (
    input  logic           clk,
    input  logic           rst_n,
    u_ifu_pc_gen_if.slave  bus
);
    import u_ifu_pc_gen_pkg::*;

    pc_state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic [EXCEPTION_NUM-1:0] cfg_q, cfg_d;
    logic                     pc_vld_q, pc_vld_d;
    logic                     ifu_kill_q, ifu_kill_d;
    logic                     exc_misalign_q, exc_misalign_d;
    logic                     core_busy_q, core_busy_d;

    // Only the misalign enable is acted on; the other enables are held for future traps
    logic unused_cfg;
    assign unused_cfg = ^cfg_q;

    // Next-state, next-PC and registered-output decode
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        cfg_d          = cfg_q;
        pc_vld_d       = 1'b0;
        ifu_kill_d     = 1'b0;
        exc_misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_pulse) begin
                    pc_d  = bus.start_pc;
                    cfg_d = bus.core_configuration;
                    if (is_misaligned(bus.start_pc[1:0]) &&
                        bus.core_configuration[EXC_MISALIGN_BIT]) begin
                        state_d        = HALT;
                        exc_misalign_d = 1'b1;
                    end else begin
                        state_d  = RUN;
                        pc_vld_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.bru_flush) begin
                    if (is_misaligned(bus.bru_redir_pc[1:0]) && cfg_q[EXC_MISALIGN_BIT]) begin
                        state_d        = HALT;
                        exc_misalign_d = 1'b1;
                    end else begin
                        // Redirect overrides a concurrent stall; the bubble kills the BRU's younger fetch
                        pc_d       = bus.bru_redir_pc;
                        state_d    = KILL;
                        ifu_kill_d = 1'b1;
                    end
                end else if (bus.id_stall) begin
                    pc_vld_d = 1'b1;
                end else begin
                    pc_d     = pc_q + PC_WIDTH'(PC_STEP);
                    pc_vld_d = 1'b1;
                end
            end
            KILL: begin
                // Any flush here belongs to the instruction being killed, so it is dropped
                state_d  = RUN;
                pc_vld_d = 1'b1;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        core_busy_d = (state_d == RUN) || (state_d == KILL);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pc_q           <= '0;
            cfg_q          <= '0;
            pc_vld_q       <= 1'b0;
            ifu_kill_q     <= 1'b0;
            exc_misalign_q <= 1'b0;
            core_busy_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            cfg_q          <= cfg_d;
            pc_vld_q       <= pc_vld_d;
            ifu_kill_q     <= ifu_kill_d;
            exc_misalign_q <= exc_misalign_d;
            core_busy_q    <= core_busy_d;
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.pc_vld       = pc_vld_q;
    assign bus.ifu_kill     = ifu_kill_q;
    assign bus.exc_misalign = exc_misalign_q;
    assign bus.core_busy    = core_busy_q;

endmodule

// File: tb/tb_u_ifu_pc_gen.sv
// tb/tb_u_ifu_pc_gen.sv - scoreboard bench for the fetch PC generator
module tb_u_ifu_pc_gen;

    typedef struct {
        logic [31:0] pc;
        logic        vld;
        logic        kill;
        logic        exc;
        logic        busy;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    exp_t exp_q[$];

    u_ifu_pc_gen_if #(.PC_WIDTH(32), .EXCEPTION_NUM(2)) bus ();

    u_ifu_pc_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 fetching, 2 bubble after redirect, 3 halted
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_trap_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Monitor: every sampled cycle pops the oldest expectation and compares all outputs
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pc_out", bus.pc_out, e.pc);
            check("pc_vld", {31'b0, bus.pc_vld}, {31'b0, e.vld});
            check("ifu_kill", {31'b0, bus.ifu_kill}, {31'b0, e.kill});
            check("exc_misalign", {31'b0, bus.exc_misalign}, {31'b0, e.exc});
            check("core_busy", {31'b0, bus.core_busy}, {31'b0, e.busy});
        end
    end

    // Drive one cycle of inputs and push the model's view of the outputs after the next edge
    task automatic step(input logic rst, input logic st, input logic [31:0] spc,
                        input logic [1:0] cfg, input logic fl, input logic [31:0] rpc,
                        input logic stl);
        exp_t e;
        logic exc;
        @(negedge clk);
        #1;
        rst_n                  = ~rst;
        bus.start_pulse        = st;
        bus.start_pc           = spc;
        bus.core_configuration = cfg;
        bus.bru_flush          = fl;
        bus.bru_redir_pc       = rpc;
        bus.id_stall           = stl;
        exc = 1'b0;
        if (rst) begin
            m_mode = 0; m_pc = 32'h0; m_trap_en = 1'b0;
        end else begin
            case (m_mode)
                0: if (st) begin
                    m_trap_en = cfg[1];
                    m_pc = spc;
                    if ((spc % 4) != 0 && m_trap_en) begin m_mode = 3; exc = 1'b1; end
                    else m_mode = 1;
                end
                1: if (fl) begin
                    if ((rpc % 4) != 0 && m_trap_en) begin m_mode = 3; exc = 1'b1; end
                    else begin m_pc = rpc; m_mode = 2; end
                end else if (!stl) begin
                    m_pc = m_pc + 32'd4;
                end
                2: m_mode = 1;
                default: ;
            endcase
        end
        e.pc   = m_pc;
        e.vld  = (m_mode == 1);
        e.kill = (m_mode == 2);
        e.exc  = exc;
        e.busy = (m_mode == 1) || (m_mode == 2);
        exp_q.push_back(e);
    endtask

    task automatic idle_cyc(); step(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic rst_cyc();  step(1, 0, 0, 0, 0, 0, 0); endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        m_mode = 0; m_pc = 0; m_trap_en = 0;
        rst_n = 1'b0;
        bus.start_pulse = 0; bus.start_pc = 0; bus.core_configuration = 0;
        bus.bru_flush = 0; bus.bru_redir_pc = 0; bus.id_stall = 0;

        rst_cyc(); rst_cyc();
        idle_cyc();
        // Sequential fetch from 0x1000, stall twice at 0x1008
        step(0, 1, 32'h1000, 2'b10, 0, 0, 0);
        idle_cyc(); idle_cyc();
        step(0, 0, 0, 0, 0, 0, 1); step(0, 0, 0, 0, 0, 0, 1);
        idle_cyc();
        // Aligned redirect with one bubble
        step(0, 0, 0, 0, 1, 32'h0000_C000, 0);
        idle_cyc(); idle_cyc();
        // Flush+stall together, then a second flush during the bubble
        step(0, 0, 0, 0, 1, 32'h0000_D000, 1);
        step(0, 0, 0, 0, 1, 32'h0000_E000, 0);
        idle_cyc(); idle_cyc();
        // Misaligned redirect traps; later start is ignored
        step(0, 0, 0, 0, 1, 32'h0000_BEEF, 0);
        idle_cyc();
        step(0, 1, 32'h2000, 2'b10, 0, 0, 0);
        idle_cyc();
        // Trapping disabled: misaligned target accepted unmasked
        rst_cyc();
        step(0, 1, 32'h2000, 2'b00, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0000_BEEF, 0);
        idle_cyc(); idle_cyc();
        // Misaligned start with trapping enabled
        rst_cyc();
        step(0, 1, 32'h3002, 2'b10, 0, 0, 0);
        idle_cyc();
        // Wrap at the top of the address space, then reset during the bubble
        rst_cyc();
        step(0, 1, 32'hFFFF_FFF8, 2'b10, 0, 0, 0);
        idle_cyc(); idle_cyc();
        step(0, 0, 0, 0, 1, 32'h0000_0040, 0);
        rst_cyc();
        idle_cyc();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, s, f, t;
            logic [31:0] spc, rpc;
            logic [1:0]  cfg;
            r   = ($urandom_range(0, 99) == 0);
            s   = ($urandom_range(0, 7) == 0);
            f   = ($urandom_range(0, 5) == 0);
            t   = ($urandom_range(0, 3) == 0);
            cfg = 2'($urandom_range(0, 3));
            spc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | {28'b0, 2'($urandom_range(0, 3)), 2'b00})
                                              : {$urandom() & 32'hFFFF_FFFC};
            if ($urandom_range(0, 9) == 0) spc[1:0] = 2'($urandom_range(1, 3));
            rpc = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step(r, s, spc, cfg, f, rpc, t);
        end

        idle_cyc();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
